spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 171 +++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
`timescale 1ns/1ps
// Two-port read arbiter in front of a single SPI flash word reader, with an
// optional one-word last-read buffer that answers repeated reads without flash traffic.
module spi_flash_arbiter #(
    parameter int RR_ENABLE    = 1,
    parameter int CACHE_ENABLE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_valid,
    input  logic [21:0] p0_addr,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [21:0] p1_addr,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    input  logic        flush,
    output logic [21:0] fl_addr,
    output logic        fl_valid,
    input  logic [31:0] fl_data,
    input  logic        fl_ready,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a port holds valid and addr until it sees a one-cycle ready
    // with rdata; ready is the only completion signal. Toward the flash, the
    // reader starts on the rising edge of fl_valid and answers with a one-cycle
    // fl_ready carrying fl_data; fl_valid always drops for at least one cycle
    // between transactions.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIT   = 2'd1,
        S_ISSUE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [21:0] r_cur_addr;
    logic        r_cur_port;
    logic        r_last_grant;
    logic        r_buf_valid;
    logic [21:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic        r_flush_pend;
    logic        r_fl_valid;
    logic [21:0] r_fl_addr;
    logic        r_p0_ready;
    logic        r_p1_ready;
    logic [31:0] r_p0_rdata;
    logic [31:0] r_p1_rdata;

    logic        w_any;
    logic        w_sel_port;
    logic [21:0] w_sel_addr;
    logic        w_hit;

    always_comb begin
        w_any = p0_valid | p1_valid;
        if (p0_valid && p1_valid) begin
            w_sel_port = (RR_ENABLE != 0) ? ~r_last_grant : 1'b0;
        end else begin
            w_sel_port = p1_valid;
        end
        w_sel_addr = w_sel_port ? p1_addr : p0_addr;
        w_hit      = (CACHE_ENABLE != 0) && r_buf_valid &&
                     (r_buf_tag == w_sel_addr) && !flush;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = w_hit ? S_HIT : S_ISSUE;
            S_HIT:   w_state_nxt = S_IDLE;
            S_ISSUE: if (fl_ready) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ready and rdata are one-cycle registered pulses, zero otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cur_addr   <= '0;
            r_cur_port   <= 1'b0;
            r_last_grant <= 1'b1;
            r_buf_valid  <= 1'b0;
            r_buf_tag    <= '0;
            r_buf_data   <= '0;
            r_flush_pend <= 1'b0;
            r_fl_valid   <= 1'b0;
            r_fl_addr    <= '0;
            r_p0_ready   <= 1'b0;
            r_p1_ready   <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_p0_ready <= 1'b0;
            r_p1_ready <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            if (flush) r_buf_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cur_addr   <= w_sel_addr;
                        r_cur_port   <= w_sel_port;
                        r_last_grant <= w_sel_port;
                        if (w_hit) begin
                            if (w_sel_port) begin
                                r_p1_ready <= 1'b1;
                                r_p1_rdata <= r_buf_data;
                            end else begin
                                r_p0_ready <= 1'b1;
                                r_p0_rdata <= r_buf_data;
                            end
                        end else begin
                            r_fl_valid <= 1'b1;
                            r_fl_addr  <= w_sel_addr;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (fl_ready) begin
                        r_fl_valid <= 1'b0;
                        if (r_cur_port) begin
                            r_p1_ready <= 1'b1;
                            r_p1_rdata <= fl_data;
                        end else begin
                            r_p0_ready <= 1'b1;
                            r_p0_rdata <= fl_data;
                        end
                        // A flush seen at any point of this read leaves the buffer empty.
                        if ((CACHE_ENABLE != 0) && !flush && !r_flush_pend) begin
                            r_buf_valid <= 1'b1;
                            r_buf_tag   <= r_cur_addr;
                            r_buf_data  <= fl_data;
                        end
                    end
                end
                S_RESP: begin
                    r_flush_pend <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign p0_ready    = r_p0_ready;
    assign p1_ready    = r_p1_ready;
    assign p0_rdata    = r_p0_rdata;
    assign p1_rdata    = r_p1_rdata;
    assign fl_valid    = r_fl_valid;
    assign fl_addr     = r_fl_addr;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
`timescale 1ns/1ps
// Bench for spi_flash_arbiter: round-robin/cached instance with a behavioural
// flash reader, plus a fixed-priority uncached instance for starvation ordering.
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        p0_valid, p1_valid;
    logic [21:0] p0_addr, p1_addr;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ready, p1_ready;
    logic        tb_flush, flush_w_ready, flush;
    logic [21:0] fl_addr;
    logic        fl_valid;
    logic [31:0] fl_data;
    logic        fl_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    logic        q0_valid, q1_valid;
    logic [21:0] q0_addr, q1_addr;
    logic [31:0] q0_rdata, q1_rdata;
    logic        q0_ready, q1_ready;
    logic [21:0] q_fl_addr;
    logic        q_fl_valid;
    logic [31:0] q_fl_data;
    logic        q_fl_ready;
    logic        q_busy;
    logic [1:0]  q_dbg_state;

    assign flush = tb_flush | (flush_w_ready & fl_ready);

    spi_flash_arbiter #(.RR_ENABLE(1), .CACHE_ENABLE(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .flush(flush), .fl_addr(fl_addr), .fl_valid(fl_valid), .fl_data(fl_data),
        .fl_ready(fl_ready), .busy(busy), .o_dbg_state(dbg_state)
    );

    spi_flash_arbiter #(.RR_ENABLE(0), .CACHE_ENABLE(0)) u_dut_fp (
        .clk(clk), .resetn(resetn),
        .p0_valid(q0_valid), .p0_addr(q0_addr), .p0_rdata(q0_rdata), .p0_ready(q0_ready),
        .p1_valid(q1_valid), .p1_addr(q1_addr), .p1_rdata(q1_rdata), .p1_ready(q1_ready),
        .flush(1'b0), .fl_addr(q_fl_addr), .fl_valid(q_fl_valid), .fl_data(q_fl_data),
        .fl_ready(q_fl_ready), .busy(q_busy), .o_dbg_state(q_dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fl_word(input logic [21:0] a);
        return (a == 22'h000010) ? 32'hDEADBEEF : (32'hC0DE0000 ^ {10'h0, a});
    endfunction

    // ---------------- flash reader models ----------------
    int   fl_lat = 4;
    int   fl_cnt;
    logic fl_prev;
    logic stray;

    always @(posedge clk) begin
        if (!resetn) begin
            fl_ready <= 1'b0;
            fl_data  <= 32'hBAD0BAD0;
            fl_cnt   <= 0;
            fl_prev  <= 1'b0;
        end else begin
            fl_prev  <= fl_valid;
            fl_ready <= 1'b0;
            fl_data  <= 32'hBAD0BAD0;
            if (stray) begin
                fl_ready <= 1'b1;
                fl_data  <= 32'h12345678;
            end
            if (fl_valid && !fl_prev) begin
                fl_cnt <= fl_lat;
            end else if (fl_cnt > 0) begin
                fl_cnt <= fl_cnt - 1;
                if (fl_cnt == 1) begin
                    fl_ready <= 1'b1;
                    fl_data  <= fl_word(fl_addr);
                end
            end
        end
    end

    int   q_cnt;
    logic q_prev;
    always @(posedge clk) begin
        if (!resetn) begin
            q_fl_ready <= 1'b0;
            q_fl_data  <= '0;
            q_cnt      <= 0;
            q_prev     <= 1'b0;
        end else begin
            q_prev     <= q_fl_valid;
            q_fl_ready <= 1'b0;
            q_fl_data  <= '0;
            if (q_fl_valid && !q_prev) begin
                q_cnt <= 3;
            end else if (q_cnt > 0) begin
                q_cnt <= q_cnt - 1;
                if (q_cnt == 1) begin
                    q_fl_ready <= 1'b1;
                    q_fl_data  <= 32'hF0000000 | {10'h0, q_fl_addr};
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];     // {hit, port, data}
    int          exp_cyc_q[$]; // request cycle for hit latency, -1 = not checked
    logic [21:0] exp_fl_q[$];
    logic [32:0] exp_fp_q[$];  // {port, data}

    int          lg_m = 1;
    logic        mv = 1'b0;
    logic [21:0] mt = '0;
    logic [31:0] md = '0;

    logic fl_valid_q = 1'b0;
    int   last_flr_cyc = -100;

    always @(negedge clk) begin
        logic [33:0] e;
        int          c;
        logic [32:0] f;
        if (resetn) begin
            if (fl_ready) last_flr_cyc = cyc;
            if (fl_valid && !fl_valid_q) begin
                if (exp_fl_q.size() == 0) check("fl_start_unexpected", 1, 0);
                else check("fl_addr", fl_addr, exp_fl_q.pop_front());
            end
            if (p0_ready && p1_ready) check("dual_ready", 1, 0);
            if (p0_ready || p1_ready) begin
                if (exp_q.size() == 0) begin
                    check("ready_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("ready_port", p1_ready, e[32]);
                    check("rdata", p1_ready ? p1_rdata : p0_rdata, e[31:0]);
                    check("other_rdata_zero", p1_ready ? p0_rdata : p1_rdata, 0);
                    if (!e[33]) check("miss_latency", cyc - last_flr_cyc, 1);
                    else if (c >= 0) check("hit_latency", cyc - c, 1);
                end
            end
            if (q0_ready || q1_ready) begin
                if (exp_fp_q.size() == 0) begin
                    check("fp_ready_unexpected", 1, 0);
                end else begin
                    f = exp_fp_q.pop_front();
                    check("fp_port", q1_ready, f[32]);
                    check("fp_rdata", q1_ready ? q1_rdata : q0_rdata, f[31:0]);
                end
            end
        end
        fl_valid_q = fl_valid;
    end

    task automatic predict(input int port, input logic [21:0] addr, input int rc, input int fmode);
        logic pb;
        pb = (port != 0);
        if (mv && mt == addr) begin
            exp_q.push_back({1'b1, pb, md});
            exp_cyc_q.push_back(rc);
        end else begin
            exp_q.push_back({1'b0, pb, fl_word(addr)});
            exp_cyc_q.push_back(-1);
            exp_fl_q.push_back(addr);
            if (fmode == 0) begin
                mv = 1'b1;
                mt = addr;
                md = fl_word(addr);
            end else begin
                mv = 1'b0;
            end
        end
        lg_m = port;
    endtask

    // fmode: 0 plain, 1 flush pulse three cycles in, 2 flush together with fl_ready
    task automatic req(input logic v0, input logic [21:0] a0, input logic v1,
                       input logic [21:0] a1, input int fmode);
        int   rc, n, first;
        logic drop0, drop1;
        @(posedge clk); #1;
        rc = cyc;
        if (v0 && v1) begin
            first = (lg_m == 1) ? 0 : 1;
            predict(first, (first == 1) ? a1 : a0, rc, fmode);
            predict(1 - first, (first == 1) ? a0 : a1, -1, fmode);
        end else if (v0) begin
            predict(0, a0, rc, fmode);
        end else begin
            predict(1, a1, rc, fmode);
        end
        p0_valid = v0; p0_addr = a0;
        p1_valid = v1; p1_addr = a1;
        flush_w_ready = (fmode == 2);
        drop0 = 1'b0; drop1 = 1'b0; n = 0;
        while ((p0_valid || p1_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
            tb_flush = (fmode == 1 && n == 3);
            // Address is latched at grant; wiggling it afterwards must not matter.
            if (!(v0 && v1)) begin
                if (v0) p0_addr = 22'($urandom_range(0, 32'h3FFFFF));
                if (v1) p1_addr = 22'($urandom_range(0, 32'h3FFFFF));
            end
            if (drop0) begin p0_valid = 1'b0; drop0 = 1'b0; end
            if (drop1) begin p1_valid = 1'b0; drop1 = 1'b0; end
            if (p0_ready) drop0 = 1'b1;
            if (p1_ready) drop1 = 1'b1;
        end
        if (n >= 400) begin
            check("req_timeout", 1, 0);
            p0_valid = 1'b0;
            p1_valid = 1'b0;
        end
        tb_flush = 1'b0;
        flush_w_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {p0_ready, p1_ready, fl_valid, busy, dbg_state, fl_addr}, 0);
        check("reset_rdata", {p0_rdata, p1_rdata}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, n;
        logic adv0, drop1, rv0, rv1;
        resetn = 1'b0;
        p0_valid = 1'b0; p1_valid = 1'b0; p0_addr = '0; p1_addr = '0;
        q0_valid = 1'b0; q1_valid = 1'b0; q0_addr = '0; q1_addr = '0;
        tb_flush = 1'b0; flush_w_ready = 1'b0; stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        resetn = 1'b1;

        fl_lat = 70;
        req(1'b1, 22'h000010, 1'b0, '0, 0);
        fl_lat = 4;
        req(1'b1, 22'h000010, 1'b0, '0, 0);

        req(1'b1, 22'h000100, 1'b1, 22'h000200, 0);
        req(1'b1, 22'h000100, 1'b0, '0, 0);
        req(1'b1, 22'h000100, 1'b1, 22'h000200, 0);

        fl_lat = 8;
        req(1'b1, 22'h000300, 1'b0, '0, 1);
        req(1'b1, 22'h000300, 1'b0, '0, 0);
        req(1'b0, '0, 1'b1, 22'h000310, 2);
        req(1'b0, '0, 1'b1, 22'h000310, 0);
        req(1'b0, '0, 1'b1, 22'h000310, 0);

        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stray_fl_ready_idle", {busy, dbg_state}, 0);
        req(1'b0, '0, 1'b1, 22'h000310, 0);

        for (int i = 0; i < 10; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            fl_lat = $urandom_range(1, 6);
            req(rv0, 22'h20 + 22'($urandom_range(0, 3)), rv1, 22'h20 + 22'($urandom_range(0, 3)), 0);
        end

        fl_lat = 70;
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_addr = 22'h000500;
        exp_fl_q.push_back(22'h000500);
        repeat (10) @(posedge clk);
        #1;
        check("mid_issue_state", {busy, fl_valid, dbg_state}, {1'b1, 1'b1, 2'd2});
        resetn = 1'b0;
        p0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_issue");
        resetn = 1'b1;
        lg_m = 1; mv = 1'b0; fl_lat = 4;
        req(1'b0, '0, 1'b1, 22'h000040, 0);
        req(1'b1, 22'h000010, 1'b0, '0, 0);

        // fixed priority: p0 keeps re-requesting, p1 waits until p0 goes quiet
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) exp_fp_q.push_back({1'b0, 32'hF0000000 | 32'(i)});
        exp_fp_q.push_back({1'b1, 32'hF0000077});
        q0_valid = 1'b1; q0_addr = 22'h1;
        q1_valid = 1'b1; q1_addr = 22'h77;
        k = 0; n = 0; adv0 = 1'b0; drop1 = 1'b0;
        while ((q0_valid || q1_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (adv0) begin
                adv0 = 1'b0;
                k++;
                if (k < 3) q0_addr = 22'(k + 1);
                else q0_valid = 1'b0;
            end
            if (drop1) begin q1_valid = 1'b0; drop1 = 1'b0; end
            if (q0_ready) adv0 = 1'b1;
            if (q1_ready) drop1 = 1'b1;
        end
        if (n >= 300) check("fp_timeout", 1, 0);

        repeat (4) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_fl_q_drained", exp_fl_q.size(), 0);
        check("exp_fp_q_drained", exp_fp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
